// File: rtl/transit_timer_pkg.sv
// Shared types and elaboration helpers for the transit timer.
// Holds the default result width, the FSM state encoding and the prescale calculation.
package transit_pkg;

    localparam int TIME_W_DEF = 19;

    typedef enum logic [1:0] {
        IDLE,
        TIMING,
        DONE
    } state_t;

    function automatic int calc_prescale(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/transit_timer_if.sv
// Sensor inputs and measurement results of the transit timer, bundled as one port.
// The master side drives the raw sensors; the slave side (the timer) drives the results.
interface transit_timer_if #(
    parameter int TIME_W = transit_pkg::TIME_W_DEF
);

    logic              sensor1;
    logic              sensor2;
    logic [TIME_W-1:0] time_out;
    logic              time_valid;
    logic              busy;
    logic              timeout;
    logic              seq_err;

    modport master (
        output sensor1, sensor2,
        input  time_out, time_valid, busy, timeout, seq_err
    );

    modport slave (
        input  sensor1, sensor2,
        output time_out, time_valid, busy, timeout, seq_err
    );

endinterface

// File: rtl/transit_timer_sensor_conditioner.sv
// Two-flop synchronizer, counting debouncer and rise detector for one track sensor.
// Fixed pipeline depth, so two instances keep the S1-to-S2 interval intact.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level,
    output logic rise
);

    localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw_in;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Counts consecutive samples that disagree with the accepted level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_level & ~r_level_d;

endmodule

// File: rtl/transit_timer.sv
// Measures the S1-to-S2 transit time in ticks of TICK_HZ, saturating into a timeout.
// Holds the measurement FSM, the clock prescaler and the tick counter.
module transit_timer
    import transit_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int TIME_W       = TIME_W_DEF,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    transit_timer_if.slave  bus
);

    localparam int PRESCALE = calc_prescale(CLK_FREQ_HZ, TICK_HZ);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("transit_timer: CLK_FREQ_HZ/TICK_HZ must be at least 1");
        end
    endgenerate

    localparam int                PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [TIME_W-1:0]  TICKS_MAX  = '1;

    logic w_s1_level, w_s1_rise;
    logic w_s2_level, w_s2_rise;
    logic w_unused;

    sensor_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (bus.sensor1),
        .level  (w_s1_level),
        .rise   (w_s1_rise)
    );

    sensor_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (bus.sensor2),
        .level  (w_s2_level),
        .rise   (w_s2_rise)
    );

    assign w_unused = w_s1_level ^ w_s2_level;

    state_t             r_state, w_state_next;
    logic [PRESC_W-1:0] r_presc;
    logic [TIME_W-1:0]  r_ticks;
    logic [TIME_W-1:0]  r_time_out;
    logic               r_time_valid, r_timeout, r_seq_err;
    logic               w_valid_next, w_timeout_next, w_seq_err_next;
    logic               w_wrap;
    logic [TIME_W-1:0]  w_ticks_inc;

    assign w_wrap      = (r_presc == PRESC_LAST);
    assign w_ticks_inc = r_ticks + TIME_W'(w_wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_valid_next   = 1'b0;
        w_timeout_next = 1'b0;
        w_seq_err_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s1_rise) begin
                    w_state_next = TIMING;
                end else if (w_s2_rise) begin
                    w_seq_err_next = 1'b1;
                end
            end
            TIMING: begin
                if (r_ticks == TICKS_MAX) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else if (w_s2_rise) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_valid_next = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The tick counter doubles as the capture register: it freezes once TIMING is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if (r_state == IDLE && w_s1_rise) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if (r_state == TIMING && r_ticks != TICKS_MAX) begin
            r_presc <= w_wrap ? '0 : r_presc + PRESC_W'(1);
            r_ticks <= w_ticks_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_out   <= '0;
            r_time_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_time_valid <= w_valid_next;
            r_timeout    <= w_timeout_next;
            r_seq_err    <= w_seq_err_next;
            if (r_state == DONE) begin
                r_time_out <= r_ticks;
            end
        end
    end

    assign bus.time_out   = r_time_out;
    assign bus.time_valid = r_time_valid;
    assign bus.timeout    = r_timeout;
    assign bus.seq_err    = r_seq_err;
    assign bus.busy       = (r_state == TIMING);

endmodule
